// File: rtl/slave_port_arbiter_if.sv
// Bundle of master-side request/response and slave-side handshake signals for
// slave_port_arbiter. The arbiter uses the slave modport; the environment uses master.
interface slave_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]        m_req;
    logic [1:0]        m_cmd;
    logic [ADDR_W-1:0] m_addr0;
    logic [ADDR_W-1:0] m_addr1;
    logic [DATA_W-1:0] m_wdata0;
    logic [DATA_W-1:0] m_wdata1;
    logic [1:0]        m_ack;
    logic [1:0]        m_resp;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;

    logic              s_req;
    logic              s_cmd;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ack;
    logic              s_resp;
    logic [DATA_W-1:0] s_rdata;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  m_req, m_cmd, m_addr0, m_addr1, m_wdata0, m_wdata1,
        input  s_ack, s_resp, s_rdata,
        output m_ack, m_resp, m_rdata, m_err,
        output s_req, s_cmd, s_addr, s_wdata,
        output grant, busy
    );

    modport master (
        output m_req, m_cmd, m_addr0, m_addr1, m_wdata0, m_wdata1,
        output s_ack, s_resp, s_rdata,
        input  m_ack, m_resp, m_rdata, m_err,
        input  s_req, s_cmd, s_addr, s_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/slave_port_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of one slave port.
// Optional watchdog abort is enabled by defining ARB_TIMEOUT_EN.
module slave_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slave_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        resp_q, resp_d;
    logic              err_q, err_d;

    logic [1:0]        elig;
    logic              win;
    logic              g_idx;
    logic              timeout;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("slave_port_arbiter: TIMEOUT must be in 1..255");
    end

    // A master still seeing its own ack/resp pulse has not dropped m_req yet.
    assign elig  = bus.m_req & ~ack_q & ~resp_q;
    assign win   = (elig == 2'b11) ? ptr_q : elig[1];
    assign g_idx = grant_q[1];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign timeout = (state_q != StIdle) && (cnt_q == TimeoutLast);

    always_comb begin
        cnt_d = '0;
        if (state_q != StIdle && state_d == state_q) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 2'b00;
        resp_d  = 2'b00;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (|elig) begin
                    state_d = StIssue;
                    grant_d = win ? 2'b10 : 2'b01;
                    cmd_d   = bus.m_cmd[win];
                    addr_d  = win ? bus.m_addr1 : bus.m_addr0;
                    wdata_d = win ? bus.m_wdata1 : bus.m_wdata0;
                end
            end
            StIssue: begin
                if (bus.s_ack) begin
                    ack_d[g_idx] = 1'b1;
                    if (cmd_q) begin
                        state_d = StIdle;
                        grant_d = 2'b00;
                        ptr_d   = ~g_idx;
                    end else begin
                        state_d = StWaitRd;
                    end
                end else if (timeout) begin
                    ack_d[g_idx] = 1'b1;
                    err_d        = 1'b1;
                    state_d      = StIdle;
                    grant_d      = 2'b00;
                    ptr_d        = ~g_idx;
                end
            end
            StWaitRd: begin
                if (bus.s_resp) begin
                    rdata_d       = bus.s_rdata;
                    resp_d[g_idx] = 1'b1;
                    state_d       = StIdle;
                    grant_d       = 2'b00;
                    ptr_d         = ~g_idx;
                end else if (timeout) begin
                    rdata_d       = '0;
                    resp_d[g_idx] = 1'b1;
                    err_d         = 1'b1;
                    state_d       = StIdle;
                    grant_d       = 2'b00;
                    ptr_d         = ~g_idx;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            grant_q <= 2'b00;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 2'b00;
            resp_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign bus.m_ack   = ack_q;
    assign bus.m_resp  = resp_q;
    assign bus.m_rdata = rdata_q;
    assign bus.m_err   = err_q;
    assign bus.s_req   = (state_q == StIssue);
    assign bus.s_cmd   = cmd_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != StIdle);

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_busy_grant:   assert property (@(posedge clk) disable iff (!rst_n)
                                     ((state_q != StIdle) == (grant_q != 2'b00)));

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_slave_port_arbiter;

    localparam int unsigned TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic [1:0] keep;
    int total;
    int bad;

    slave_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    slave_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the slave, whether data is still awaited,
    // and who wins the next tie.
    int          owner;
    bit          waiting_data;
    int          tie_winner;
    int          age;
    logic        cur_cmd;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_ack;
    logic [1:0]  exp_resp;
    logic        exp_err;

    task automatic model_reset();
        owner        = -1;
        waiting_data = 1'b0;
        tie_winner   = 0;
        age          = 0;
        cur_cmd      = 1'b0;
        cur_addr     = '0;
        cur_wdata    = '0;
        exp_rdata    = '0;
        exp_ack      = 2'b00;
        exp_resp     = 2'b00;
        exp_err      = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] nack;
        logic [1:0] nresp;
        logic       nerr;
        bit         done;
        bit         want0;
        bit         want1;
        nack  = 2'b00;
        nresp = 2'b00;
        nerr  = 1'b0;
        done  = 1'b0;
        if (owner < 0) begin
            want0 = bus.m_req[0] && !exp_ack[0] && !exp_resp[0];
            want1 = bus.m_req[1] && !exp_ack[1] && !exp_resp[1];
            if (want0 || want1) begin
                owner        = (want0 && want1) ? tie_winner : (want0 ? 0 : 1);
                cur_cmd      = bus.m_cmd[owner];
                cur_addr     = (owner == 1) ? bus.m_addr1 : bus.m_addr0;
                cur_wdata    = (owner == 1) ? bus.m_wdata1 : bus.m_wdata0;
                waiting_data = 1'b0;
                age          = 0;
            end
        end else if (!waiting_data) begin
            age++;
            if (bus.s_ack) begin
                nack[owner] = 1'b1;
                if (cur_cmd) begin
                    done = 1'b1;
                end else begin
                    waiting_data = 1'b1;
                    age          = 0;
                end
            end else if (TO_EN && age == int'(TO)) begin
                nack[owner] = 1'b1;
                nerr        = 1'b1;
                done        = 1'b1;
            end
        end else begin
            age++;
            if (bus.s_resp) begin
                nresp[owner] = 1'b1;
                exp_rdata    = bus.s_rdata;
                done         = 1'b1;
            end else if (TO_EN && age == int'(TO)) begin
                nresp[owner] = 1'b1;
                nerr         = 1'b1;
                exp_rdata    = '0;
                done         = 1'b1;
            end
        end
        if (done) begin
            tie_winner   = 1 - owner;
            owner        = -1;
            waiting_data = 1'b0;
        end
        exp_ack  = nack;
        exp_resp = nresp;
        exp_err  = nerr;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        logic       e_sreq;
        logic [1:0] e_grant;
        forever begin
            @(negedge clk);
            e_sreq  = (owner >= 0) && !waiting_data;
            e_grant = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
            check("pulses", {bus.m_ack, bus.m_resp, bus.m_err}, {exp_ack, exp_resp, exp_err});
            check("rdata", bus.m_rdata, exp_rdata);
            check("slave", {bus.s_req, bus.s_cmd, bus.s_addr, bus.s_wdata},
                  {e_sreq, cur_cmd, cur_addr, cur_wdata});
            check("grant", {bus.grant, bus.busy}, {e_grant, owner >= 0});
        end
    end

    // Advance one edge; masters drop their request once acknowledged unless held.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (bus.m_ack[i] && !keep[i]) bus.m_req[i] = 1'b0;
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.m_ack, bus.m_resp, bus.m_rdata, bus.m_err, bus.s_req, bus.s_cmd,
                bus.s_addr, bus.s_wdata, bus.grant, bus.busy};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        keep  = 2'b00;
        bus.m_req    = 2'b00;
        bus.m_cmd    = 2'b00;
        bus.m_addr0  = '0;
        bus.m_addr1  = '0;
        bus.m_wdata0 = '0;
        bus.m_wdata1 = '0;
        bus.s_ack    = 1'b0;
        bus.s_resp   = 1'b0;
        bus.s_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", all_outs(), '0);
        rst_n = 1'b1;
        tick();

        // Contention from reset: M0 then M1, twice.
        bus.m_cmd    = 2'b11;
        bus.m_addr0  = 32'h100;
        bus.m_addr1  = 32'h200;
        bus.m_wdata0 = 32'h1;
        bus.m_wdata1 = 32'h2;
        bus.m_req    = 2'b11;
        bus.s_ack    = 1'b1;
        tick();
        check("ct_first", bus.grant, 2'b01);
        tick();
        tick();
        check("ct_second", bus.grant, 2'b10);
        tick();
        bus.m_req = 2'b11;
        tick();
        check("ct_rep_first", bus.grant, 2'b01);
        tick();
        tick();
        check("ct_rep_second", bus.grant, 2'b10);
        tick();
        bus.s_ack = 1'b0;
        tick();

        // Single write from M0, s_ack in the third issue cycle.
        bus.m_cmd[0] = 1'b1;
        bus.m_addr0  = 32'h10;
        bus.m_wdata0 = 32'hA5;
        bus.m_req[0] = 1'b1;
        tick();
        check("wr_issue", {bus.s_req, bus.s_addr, bus.s_wdata, bus.grant},
              {1'b1, 32'h10, 32'hA5, 2'b01});
        tick();
        tick();
        check("wr_still_req", bus.s_req, 1'b1);
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        check("wr_ack", {bus.m_ack, bus.s_req, bus.grant}, {2'b01, 1'b0, 2'b00});
        tick();
        check("wr_ack_pulse", bus.m_ack, 2'b00);

        // Single read from M1.
        bus.m_cmd[1] = 1'b0;
        bus.m_addr1  = 32'h20;
        bus.m_req[1] = 1'b1;
        tick();
        check("rd_issue", {bus.s_req, bus.s_cmd, bus.s_addr}, {1'b1, 1'b0, 32'h20});
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        check("rd_ack", {bus.m_ack, bus.s_req, bus.busy}, {2'b10, 1'b0, 1'b1});
        tick();
        bus.s_resp  = 1'b1;
        bus.s_rdata = 32'hDEADBEEF;
        tick();
        bus.s_resp  = 1'b0;
        bus.s_rdata = '0;
        check("rd_resp", {bus.m_resp, bus.m_rdata}, {2'b10, 32'hDEADBEEF});
        tick();
        check("rd_hold", {bus.m_resp, bus.m_rdata, bus.grant}, {2'b00, 32'hDEADBEEF, 2'b00});

        // Continuous M0 traffic; M1 asks once and is served next.
        keep[0]      = 1'b1;
        bus.m_cmd    = 2'b11;
        bus.m_addr0  = 32'h40;
        bus.m_addr1  = 32'h50;
        bus.m_req[0] = 1'b1;
        bus.s_ack    = 1'b1;
        tick();
        check("cont_m0", bus.grant, 2'b01);
        bus.m_req[1] = 1'b1;
        tick();
        tick();
        check("cont_m1", {bus.grant, bus.s_addr}, {2'b10, 32'h50});
        tick();
        tick();
        check("cont_m0_again", bus.grant, 2'b01);
        keep[0] = 1'b0;
        tick();
        tick();
        bus.s_ack = 1'b0;
        tick();

        // Latched fields ignore later master changes.
        bus.m_cmd[0] = 1'b1;
        bus.m_addr0  = 32'h30;
        bus.m_wdata0 = 32'h33;
        bus.m_req[0] = 1'b1;
        tick();
        bus.m_addr0  = 32'h999;
        bus.m_wdata0 = 32'h888;
        tick();
        check("stable", {bus.s_addr, bus.s_wdata}, {32'h30, 32'h33});
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        tick();

        // Slave never answers.
        bus.m_addr0  = 32'h70;
        bus.m_wdata0 = 32'h77;
        bus.m_req[0] = 1'b1;
        tick();
        repeat (3) tick();
        check("to_early", bus.m_ack, 2'b00);
        tick();
`ifdef ARB_TIMEOUT_EN
        check("to_issue", {bus.m_ack, bus.m_err, bus.busy}, {2'b01, 1'b1, 1'b0});
        tick();
        bus.m_cmd[1] = 1'b0;
        bus.m_addr1  = 32'h80;
        bus.m_req[1] = 1'b1;
        tick();
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        repeat (3) tick();
        check("to_rd_early", bus.m_resp, 2'b00);
        tick();
        check("to_rd", {bus.m_resp, bus.m_err, bus.m_rdata}, {2'b10, 1'b1, 32'h0});
        tick();
`else
        check("no_to", {bus.m_ack, bus.m_err, bus.busy}, {2'b00, 1'b0, 1'b1});
        repeat (15) tick();
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        check("late_ack", {bus.m_ack, bus.m_err}, {2'b01, 1'b0});
        tick();
`endif

        // Reset during WAIT_RD.
        bus.m_cmd[1] = 1'b0;
        bus.m_addr1  = 32'h90;
        bus.m_req[1] = 1'b1;
        tick();
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        tick();
        check("pre_rst_busy", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid", all_outs(), '0);
        tick();
        tick();
        rst_n       = 1'b1;
        bus.s_resp  = 1'b1;
        bus.s_rdata = 32'h1234;
        tick();
        bus.s_resp  = 1'b0;
        bus.s_rdata = '0;
        check("rst_no_resp", {bus.m_resp, bus.m_rdata, bus.busy}, '0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_port_arbiter.md
# slave_port_arbiter

Two-master, one-slave request arbiter and sequencer for the master/slave interconnect. It sits in front of each slave port, after the per-master request blocks. It grants one pending master request at a time, using round-robin priority, and forwards the latched command, address and write data to the slave. It then runs the slave ack/response handshake and returns ack, response and read data to the granted master only.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, watchdog limit in cycles (1..255); used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_req  in  2  request per master; master i holds it high until m_ack[i]
- m_cmd  in  2  per-master command, 1 = WRITE, 0 = READ
- m_addr0, m_addr1  in  ADDR_W  per-master address
- m_wdata0, m_wdata1  in  DATA_W  per-master write data
- m_ack  out  2  one-cycle acceptance pulse to the granted master
- m_resp  out  2  one-cycle read-data-valid pulse to the granted master
- m_rdata  out  DATA_W  read data, valid while m_resp[i] is high
- m_err  out  1  abort flag, qualifies the m_ack/m_resp pulse in the same cycle
- s_req  out  1  request to slave, held until s_ack
- s_cmd  out  1  latched command
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_ack  in  1  slave accepted the request
- s_resp  in  1  slave read data valid (reads only)
- s_rdata  in  DATA_W  slave read data
- grant  out  2  one-hot owner of the slave; 00 when idle
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Eligible requesters are m_req[i], excluding any master whose m_ack[i] or m_resp[i] is high in the current cycle.
  - If both masters are eligible, the priority pointer wins. If one is eligible, it wins.
  - At the next edge, latch the winner's cmd/addr/wdata, set grant, and go to ISSUE.
- ISSUE:
  - s_req = 1 with the latched fields.
  - When s_ack is sampled high, m_ack[g] is high for the next cycle.
  - If WRITE, go to IDLE and hand priority to the other master.
  - If READ, go to WAIT_RD.
- WAIT_RD:
  - When s_resp is sampled high, capture s_rdata into m_rdata.
  - m_resp[g] is high for the next cycle.
  - Go to IDLE and hand priority to the other master.
  - s_resp seen in any other state is ignored.
- Priority pointer resets to master 0 and changes only on transaction completion.
- Latched fields are stable for the whole transaction; later m_* changes are ignored.
- m_rdata holds its last value between responses.

## Timing
- Reset (async, immediate):
  - State = IDLE, pointer = 0.
  - All outputs 0: m_ack, m_resp, m_rdata, m_err, s_req, s_cmd, s_addr, s_wdata, grant, busy.
- Reset mid-transaction aborts it silently; no ack or response is produced.
- m_req to s_req: 1 cycle. s_ack to m_ack: 1 cycle. s_resp to m_resp: 1 cycle.
- s_req drops in the cycle after s_ack is sampled.
- With s_ack already high on entering ISSUE, a write completes in 2 cycles from grant.
- Back-to-back: a new grant can start in the cycle after m_ack (write) or m_resp (read).
- grant and busy are registered and change on the same edges as the state.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering ISSUE or WAIT_RD and increments each cycle in those states.
  - When it reaches TIMEOUT without s_ack or s_resp, the transaction aborts.
  - Abort in ISSUE: m_ack[g] = 1 and m_err = 1, then go to IDLE. A read is not continued.
  - Abort in WAIT_RD: m_resp[g] = 1, m_err = 1, m_rdata = 0, then go to IDLE.
  - Priority is handed over exactly as on normal completion.
- ARB_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; m_err is constant 0.

## Test plan
- Single write: M0 WRITE addr 0x10, wdata 0xA5, s_ack after 3 cycles -> s_req high 3 cycles with addr 0x10/0xA5; m_ack = 01 one cycle; grant = 00 after.
- Single read: M1 READ addr 0x20; s_ack, then s_resp 2 cycles later with 0xDEADBEEF -> m_ack = 10, then m_resp = 10 with m_rdata = 0xDEADBEEF.
- Contention: both masters request WRITE in the same cycle from reset -> M0 served first, then M1 with no idle gap beyond one IDLE cycle. Repeat the pair -> order M0, M1 (alternation holds).
- Continuous M0 requests while M1 requests once -> M1 granted immediately after the current M0 transaction.
- Field stability: change m_addr0 during ISSUE -> s_addr keeps the latched value.
- Reset and timeout:
  - Assert rst_n low during WAIT_RD -> all outputs 0 immediately; no m_resp after release.
  - With ARB_TIMEOUT_EN and TIMEOUT = 4, no s_ack -> m_ack pulse with m_err = 1 exactly 4 cycles after entering ISSUE.
